// File: rtl/alu_nibble_packer_if.sv
// alu_nibble_packer_if
//   Bundles the nibble input stream and the packed-word output handshake
//   of alu_nibble_packer.
//
//   Nibble side (valid-only, no backpressure):
//     nib_valid, nib_data[3:0], nib_last
//   Word side (valid/ready):
//     word_valid, word_ready, word_data[4*NIBBLES-1:0], word_zero, word_partial
//
//   Handshake rule: a word transfers on a rising edge where word_valid and
//   word_ready are both 1. While word_valid=1 and word_ready=0 the head
//   (word_data/word_zero/word_partial) is held stable. word_valid never
//   depends on word_ready.
//
//   Modports:
//     master - the environment: drives nibbles and word_ready
//     slave  - the packer: consumes nibbles, presents words
interface alu_nibble_packer_if #(
    parameter int NIBBLES = 4
);
    logic                   nib_valid;
    logic [3:0]             nib_data;
    logic                   nib_last;
    logic                   word_valid;
    logic                   word_ready;
    logic [4*NIBBLES-1:0]   word_data;
    logic                   word_zero;
    logic                   word_partial;

    modport master (
        output nib_valid, nib_data, nib_last, word_ready,
        input  word_valid, word_data, word_zero, word_partial
    );

    modport slave (
        input  nib_valid, nib_data, nib_last, word_ready,
        output word_valid, word_data, word_zero, word_partial
    );
endinterface

// File: rtl/alu_nibble_packer.sv
// alu_nibble_packer
//   Packs a stream of 4-bit nibbles LSB-first into words of NIBBLES nibbles,
//   queues completed words in a DEPTH-entry FIFO and presents them on a
//   valid/ready output. A word that completes while the FIFO is full (and
//   not popping on the same edge) is dropped and sets a sticky overflow flag.
//
//   Ports:
//     clk        - clock, rising edge
//     rst_n      - asynchronous active-low reset
//     io         - alu_nibble_packer_if.slave (nibble input, word output)
//     fifo_level - words currently queued (0..DEPTH)
//     overflow   - sticky, a completed word was dropped
//     clr_ovf    - synchronous clear of overflow (a same-edge drop wins)
module alu_nibble_packer #(
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_nibble_packer_if.slave         io,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Assembly state
    logic [W-1:0]  asm_data;
    logic [IW-1:0] nib_idx;

    // FIFO state
    logic [W-1:0]  mem_data [DEPTH];
    logic          mem_zero [DEPTH];
    logic          mem_part [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic [W-1:0]  merged;
    logic          done;
    logic          partial;
    logic          zero;
    logic          pop;
    logic          push;
    logic          drop;

    // Current assembly with the incoming nibble placed at nib_idx and every
    // nibble above it forced to zero, so an early close never leaks stale data.
    always_comb begin
        merged = asm_data;
        for (int k = 0; k < NIBBLES; k++) begin
            if (k == int'(nib_idx)) begin
                merged[4*k +: 4] = io.nib_data;
            end else if (k > int'(nib_idx)) begin
                merged[4*k +: 4] = 4'h0;
            end
        end
    end

    assign done    = io.nib_valid && ((nib_idx == LAST_IDX) || io.nib_last);
    assign partial = (nib_idx != LAST_IDX);
    assign zero    = (merged == '0);

    assign io.word_valid = (level != '0);
    assign pop           = io.word_valid && io.word_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push          = done && ((level < FULL_LVL) || pop);
    assign drop          = done && !push;

    assign io.word_data    = io.word_valid ? mem_data[rd_ptr] : '0;
    assign io.word_zero    = io.word_valid ? mem_zero[rd_ptr] : 1'b0;
    assign io.word_partial = io.word_valid ? mem_part[rd_ptr] : 1'b0;
    assign fifo_level      = level;

    // Assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_data <= '0;
            nib_idx  <= '0;
        end else if (io.nib_valid) begin
            if (done) begin
                asm_data <= '0;
                nib_idx  <= '0;
            end else begin
                asm_data <= merged;
                nib_idx  <= nib_idx + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until the level marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= merged;
            mem_zero[wr_ptr] <= zero;
            mem_part[wr_ptr] <= partial;
        end
    end

    // FIFO pointers and level; pointers wrap naturally because DEPTH is 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_nibble_packer.sv
// tb_alu_nibble_packer
//   Directed bench for alu_nibble_packer with NIBBLES=4, DEPTH=2.
//   Expected words are written by hand into exp_q and compared as they
//   leave the FIFO; other observations are compared to hand-computed values.
module tb_alu_nibble_packer;
    localparam int NIBBLES = 4;
    localparam int DEPTH   = 2;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    logic clr_ovf;
    logic [$clog2(DEPTH):0] fifo_level;
    logic overflow;

    alu_nibble_packer_if #(.NIBBLES(NIBBLES)) bus ();

    alu_nibble_packer #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; observations are taken 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] d, input logic last);
        bus.nib_valid = 1'b1;
        bus.nib_data  = d;
        bus.nib_last  = last;
        step();
        bus.nib_valid = 1'b0;
        bus.nib_last  = 1'b0;
        bus.nib_data  = 4'h0;
    endtask

    task automatic send_word(input logic [3:0] d);
        for (int i = 0; i < NIBBLES; i++) send_nib(d, 1'b0);
    endtask

    // Compare the head with the scoreboard front, then pop it.
    task automatic pop_expect(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
            check({tag, "_data"}, 32'(bus.word_data), 32'(e));
        end
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        clr_ovf        = 1'b0;
        bus.nib_valid  = 1'b0;
        bus.nib_data   = 4'h0;
        bus.nib_last   = 1'b0;
        bus.word_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid",   32'(bus.word_valid),   32'd0);
        check("rst_data",    32'(bus.word_data),    32'd0);
        check("rst_level",   32'(fifo_level),       32'd0);
        check("rst_ovf",     32'(overflow),         32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Full word, ready held high
        bus.word_ready = 1'b1;
        send_nib(4'h1, 1'b0);
        send_nib(4'h2, 1'b0);
        send_nib(4'h3, 1'b0);
        check("full_not_yet", 32'(bus.word_valid), 32'd0);
        send_nib(4'h4, 1'b0);
        check("full_valid",   32'(bus.word_valid),   32'd1);
        check("full_data",    32'(bus.word_data),    32'h4321);
        check("full_zero",    32'(bus.word_zero),    32'd0);
        check("full_partial", 32'(bus.word_partial), 32'd0);
        check("full_level",   32'(fifo_level),       32'd1);
        step();
        check("full_popped",  32'(fifo_level),       32'd0);
        bus.word_ready = 1'b0;

        // Early close, then a full word; order preserved
        send_nib(4'hA, 1'b0);
        send_nib(4'hB, 1'b1);
        check("early_level",   32'(fifo_level),       32'd1);
        check("early_partial", 32'(bus.word_partial), 32'd1);
        exp_q.push_back(16'h00BA);
        send_nib(4'hC, 1'b0);
        send_nib(4'hD, 1'b0);
        send_nib(4'hE, 1'b0);
        send_nib(4'hF, 1'b0);
        exp_q.push_back(16'hFEDC);
        check("early_level2", 32'(fifo_level), 32'd2);
        pop_expect("early_w0");
        check("second_partial", 32'(bus.word_partial), 32'd0);
        pop_expect("early_w1");
        check("early_empty", 32'(fifo_level), 32'd0);

        // Zero word with gaps; nib_last without nib_valid is ignored
        send_nib(4'h0, 1'b0);
        bus.nib_last = 1'b1;
        step();
        bus.nib_last = 1'b0;
        send_nib(4'h0, 1'b0);
        step();
        send_nib(4'h0, 1'b0);
        bus.nib_last = 1'b1;
        step();
        bus.nib_last = 1'b0;
        check("zero_no_early", 32'(fifo_level), 32'd0);
        send_nib(4'h0, 1'b0);
        check("zero_level",   32'(fifo_level),       32'd1);
        check("zero_flag",    32'(bus.word_zero),    32'd1);
        check("zero_partial", 32'(bus.word_partial), 32'd0);
        exp_q.push_back(16'h0000);
        pop_expect("zero_w");

        // Overflow and recovery
        send_word(4'h1);
        exp_q.push_back(16'h1111);
        send_word(4'h2);
        exp_q.push_back(16'h2222);
        check("ovf_before", 32'(overflow), 32'd0);
        send_word(4'h3);
        check("ovf_level", 32'(fifo_level), 32'd2);
        check("ovf_set",   32'(overflow),   32'd1);
        pop_expect("ovf_w0");
        pop_expect("ovf_w1");
        check("ovf_drained", 32'(bus.word_valid), 32'd0);
        check("ovf_sticky",  32'(overflow),       32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        send_word(4'h4);
        exp_q.push_back(16'h4444);
        send_word(4'h5);
        exp_q.push_back(16'h5555);
        send_nib(4'h6, 1'b0);
        send_nib(4'h6, 1'b0);
        send_nib(4'h6, 1'b0);
        clr_ovf = 1'b1;
        send_nib(4'h6, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(overflow),   32'd1);
        check("ovf_level2",   32'(fifo_level), 32'd2);

        // Full FIFO with a pop on the completing edge
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("pp_clear", 32'(overflow), 32'd0);
        send_nib(4'h7, 1'b0);
        send_nib(4'h7, 1'b0);
        send_nib(4'h7, 1'b0);
        check("pp_head", 32'(bus.word_data), 32'h4444);
        void'(exp_q.pop_front());
        bus.word_ready = 1'b1;
        send_nib(4'h7, 1'b0);
        bus.word_ready = 1'b0;
        exp_q.push_back(16'h7777);
        check("pp_level", 32'(fifo_level), 32'd2);
        check("pp_ovf",   32'(overflow),   32'd0);
        pop_expect("pp_w0");
        pop_expect("pp_w1");
        check("pp_empty", 32'(fifo_level), 32'd0);

        // Reset mid-operation
        send_word(4'h9);
        send_nib(4'h1, 1'b0);
        send_nib(4'h2, 1'b0);
        check("mid_level", 32'(fifo_level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid",   32'(bus.word_valid),   32'd0);
        check("mid_data",    32'(bus.word_data),    32'd0);
        check("mid_partial", 32'(bus.word_partial), 32'd0);
        check("mid_level0",  32'(fifo_level),       32'd0);
        step();
        rst_n = 1'b1;
        send_nib(4'h5, 1'b0);
        send_nib(4'h6, 1'b0);
        check("post_no_word", 32'(fifo_level), 32'd0);
        send_nib(4'h7, 1'b0);
        send_nib(4'h8, 1'b0);
        exp_q.push_back(16'h8765);
        check("post_level",   32'(fifo_level),       32'd1);
        check("post_partial", 32'(bus.word_partial), 32'd0);
        pop_expect("post_w");
        check("post_empty", 32'(fifo_level), 32'd0);
        check("q_drained",  32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_nibble_packer.md
# alu_nibble_packer

Downstream collector for the 4-bit ALU slice stage. It accepts the slice's registered result nibbles on a valid-only interface with no backpressure, and packs consecutive nibbles LSB-first into a word of NIBBLES×4 bits. Completed words are queued in a small FIFO and presented on a valid/ready output. Any word that completes while the FIFO is full is dropped and flagged.

## Interface
- NIBBLES, 4: nibbles per word; word width W = 4*NIBBLES; range 2..8.
- DEPTH, 2: output FIFO depth in words; power of two, at least 2.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nib_valid  in  1  nibble present this cycle; driven from the slice's v_out.
- nib_data  in  4  nibble value; driven from the slice's result.
- nib_last  in  1  closes the current word early; qualified by nib_valid.
- word_valid  out  1  FIFO head holds a word.
- word_ready  in  1  consumer accepts the head when word_valid=1.
- word_data  out  W  head word; nibble k is at bits [4k+3:4k].
- word_zero  out  1  head word is all zeros.
- word_partial  out  1  head word was closed by nib_last before NIBBLES nibbles.
- fifo_level  out  clog2(DEPTH)+1  words currently queued.
- overflow  out  1  sticky; a completed word was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- **Assembly state:** asm_data (W bits) and nib_idx (0..NIBBLES-1).
- **Nibble accept:** on an edge with nib_valid=1, write nib_data into asm_data nibble nib_idx.
  - Nibbles are never refused; there is no backpressure toward the slice.
- **Word completion:** a word completes when nib_idx = NIBBLES-1 or nib_last = 1.
  - Completed word = asm_data with the new nibble, and all nibbles above nib_idx forced to 0.
  - partial = (nib_idx != NIBBLES-1).
  - zero = (completed word == 0).
  - Push the completed word to the FIFO, then reset nib_idx to 0 and clear asm_data to 0.
- **No completion:** if the nibble does not complete a word, nib_idx increments.
- **Idle cycles:** when nib_valid=0, assembly state holds and nib_last is ignored. Gaps between nibbles are legal.
- **FIFO:**
  - Pop when word_valid & word_ready.
  - Push when a word completes and (level < DEPTH, or a pop occurs on the same edge).
  - Push and pop on the same edge leave the level unchanged.
  - Order is strictly first-in, first-out.
- **Drop:** if a word completes while level = DEPTH and no pop occurs on that edge:
  - The word is discarded.
  - overflow is set.
  - Assembly still resets, so the next nibble starts a new word.
- **Overflow flag:** clr_ovf=1 clears it. If a drop and clr_ovf coincide, the set wins and overflow stays 1.
- **Head outputs:** word_data, word_zero and word_partial are stored with each entry. Their values are undefined-but-stable while word_valid=0 (implementation drives 0).

## Timing
- **Reset (async assert, any time):**
  - word_valid=0, word_data=0, word_zero=0, word_partial=0, fifo_level=0, overflow=0.
  - nib_idx=0, asm_data=0.
  - A partially assembled word is lost.
  - FIFO contents are discarded.
- **Release:** first edge with rst_n=1 operates normally.
- **Latency:** a completing nibble sampled at edge k gives word_valid=1 with that word in the cycle after edge k (1 cycle) when the FIFO was empty.
- **Throughput:** sustained 1 nibble/cycle; 1 word per NIBBLES cycles. With word_ready held high the FIFO never fills.
- **Head handshake:**
  - Head is held stable while word_valid=1 and word_ready=0.
  - After a pop, the next entry (if any) appears in the following cycle.
  - A push to an empty FIFO at the same edge as nothing else appears 1 cycle later.
- **Level changes:** fifo_level changes at most by ±1 per edge and reflects state after the edge.
- **Flag timing:** overflow rises in the cycle after the dropping edge.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH; nib_idx wraps only via completion, never by overflowing its counter.

## Test plan
- **Full word:** NIBBLES=4, nibbles 0x1,0x2,0x3,0x4 on consecutive cycles, word_ready=1 → one cycle after the 4th, word_data=0x4321, word_zero=0, word_partial=0, fifo_level=1, popped next edge.
- **Early close:** nibbles 0xA, then 0xB with nib_last=1, then 0xC,0xD,0xE,0xF → first word 0x00BA with partial=1; second word 0xFEDC with partial=0; order preserved.
- **Zero word and gaps:** four 0x0 nibbles separated by idle cycles → word 0x0000 with word_zero=1; nib_last asserted with nib_valid=0 has no effect.
- **Overflow and recovery:** DEPTH=2, word_ready=0, push 3 full words (0x1111, 0x2222, 0x3333) → fifo_level=2, overflow=1, 0x3333 lost. Then word_ready=1 → pops 0x1111, 0x2222. clr_ovf → overflow=0; a clr_ovf coinciding with a new drop leaves overflow=1.
- **Full FIFO with simultaneous pop:** FIFO full, word_ready=1 on the same edge a word completes → word accepted, level stays 2, overflow stays 0.
- **Reset mid-operation:** 2 nibbles in, 1 word queued; assert rst_n=0 mid-cycle → all outputs 0 immediately. After release, nibbles 0x5,0x6,0x7,0x8 → word 0x8765 only, with no trace of earlier data.
